tc_sram_rsp_adapter: RTL and testbench
======================================

Name: tc_sram_rsp_adapter

Overview:
- Valid/ready front-end that sits directly upstream of `tc_sram` (single port, fixed `Latency`) and drives its request port.
- Converts the SRAM's fire-and-forget, fixed-latency interface into a backpressurable request/response stream.
- Uses credit-based flow control plus a response FIFO, so no read data is lost when the consumer stalls.
- Every accepted request, read or write, produces exactly one in-order response.

Parameters:
- NumWords, 1024, words in the downstream SRAM.
- DataWidth, 32, data width in bits.
- ByteWidth, 8, bits per byte-enable lane.
- Latency, 1, SRAM read latency in cycles; must be >= 1.
- RspDepth, Latency+2, response credits and FIFO entries; must be >= 1. Full throughput requires >= Latency+2.
- AddrWidth, (NumWords>1)?$clog2(NumWords):1, derived; do not override.
- BeWidth, ceil(DataWidth/ByteWidth), derived; do not override.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- req_valid_i, in, 1, request valid.
- req_ready_o, out, 1, request ready.
- req_we_i, in, 1, 1 = write, 0 = read.
- req_addr_i, in, AddrWidth, word address.
- req_wdata_i, in, DataWidth, write data.
- req_be_i, in, BeWidth, byte enables.
- rsp_valid_o, out, 1, response valid.
- rsp_ready_i, in, 1, response ready.
- rsp_rdata_o, out, DataWidth, read data; 0 for write responses.
- rsp_we_o, out, 1, response belongs to a write.
- rsp_err_o, out, 1, address error (see Optional Feature).
- sram_req_o, out, 1, to tc_sram req_i.
- sram_we_o, out, 1, to tc_sram we_i.
- sram_addr_o, out, AddrWidth, to tc_sram addr_i.
- sram_wdata_o, out, DataWidth, to tc_sram wdata_i.
- sram_be_o, out, BeWidth, to tc_sram be_i.
- sram_rdata_i, in, DataWidth, from tc_sram rdata_o.

Behaviour:
- Clocking and reset:
  - Single clock clk_i.
  - rst_i is synchronous and active-high; it clears the credit counter, the tag pipeline and the FIFO pointers.
  - While rst_i is high: req_ready_o=0, sram_req_o=0, rsp_valid_o=0.
  - Reset mid-operation drops all in-flight and buffered responses; none appear after reset.
- Credits:
  - `used` register = in-flight requests + FIFO occupancy, range 0..RspDepth.
  - req_ready_o = (used < RspDepth). It is a function of registered state only; there is no combinational path from rsp_ready_i or req_valid_i.
  - Accept = req_valid_i & req_ready_o.
  - Pop = rsp_valid_o & rsp_ready_i.
  - used_next = used + accept - pop. Simultaneous accept and pop leaves `used` unchanged.
- SRAM drive:
  - sram_req_o = accept (combinational).
  - sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o pass through from req_* unchanged.
- Tag pipeline:
  - Latency-stage shift register carrying {valid, we, err}.
  - Stage 0 is loaded with {accept, req_we_i, err} at the accept edge.
  - When the last stage is valid, at that edge the FIFO is written with {sram_rdata_i, or 0 if we; we; err}.
  - sram_rdata_i is sampled exactly Latency cycles after the accept cycle.
- Response FIFO:
  - RspDepth entries, registered output, head shown on rsp_* when non-empty.
  - Simultaneous push and pop is supported, including push into a full FIFO with pop in the same cycle.
  - Overflow is impossible by the credit invariant; an assertion (simulation only) fires on push into a full FIFO without a pop.
- Timing:
  - Latency from accept cycle C to first rsp_valid_o is cycle C+Latency+1.
  - With rsp_ready_i held at 1 and RspDepth >= Latency+2, one request per cycle is sustained.
- Ordering: responses are strictly in acceptance order.
- Payload stability: rsp_* hold stable while rsp_valid_o=1 & rsp_ready_i=0.
- Reset values: req_ready_o=0 during reset and 1 after (used=0); rsp_valid_o=0, rsp_rdata_o=0, rsp_we_o=0, rsp_err_o=0; sram_* follow req_* combinationally with sram_req_o=0.

Optional Feature:
- Macro: TC_SRAM_RSP_ADAPTER_ADDR_CHECK_EN.
- Defined:
  - An accepted request with req_addr_i >= NumWords is not forwarded (sram_req_o=0 that cycle).
  - It still consumes a credit and a tag with err=1.
  - Its response carries rsp_err_o=1 and rsp_rdata_o=0 at the normal latency, in order.
- Undefined: rsp_err_o is tied to 0 and every accepted request is forwarded unchanged.

Test Plan:
All scenarios use DataWidth=32, ByteWidth=8, NumWords=12, Latency=1, RspDepth=3 unless noted.
- Write addr 3, data 0xDEADBEEF, be 0xF; then read addr 3 → write response rsp_we_o=1, rdata 0; read response rdata 0xDEADBEEF, rsp_valid_o two cycles after the read is accepted.
- Write 0x11223344 to addr 5, then write 0xAABBCCDD with be=0b0010, then read addr 5 → rdata 0x1122CC44.
- 8 back-to-back reads of addrs 0..7 with rsp_ready_i=1 → req_ready_o stays 1, 8 in-order responses on consecutive cycles.
- rsp_ready_i=0 while req_valid_i=1 → exactly 3 accepts, then req_ready_o=0 with rsp_* stable. Raise rsp_ready_i → 3 in-order responses; req_ready_o returns to 1 the cycle after the first pop.
- rst_i pulsed for 1 cycle with 2 reads in flight → sram_req_o=0 and req_ready_o=0 during reset; no response appears afterwards; `used` is 0.
- With TC_SRAM_RSP_ADAPTER_ADDR_CHECK_EN defined, read addr 13 → sram_req_o stays 0; response with rsp_err_o=1, rdata 0, at cycle C+2. Without the macro: sram_req_o=1 and rsp_err_o=0.

Source files
------------

// File: rtl/tc_sram_rsp_adapter.sv
// Valid/ready request/response front-end for a fixed-latency tc_sram.
// Optional macro TC_SRAM_RSP_ADAPTER_ADDR_CHECK_EN rejects out-of-range addresses.
module tc_sram_rsp_adapter #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RspDepth  = Latency + 2,
   parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 rsp_we_o,
   output logic                 rsp_err_o,
   output logic                 sram_req_o,
   output logic                 sram_we_o,
   output logic [AddrWidth-1:0] sram_addr_o,
   output logic [DataWidth-1:0] sram_wdata_o,
   output logic [BeWidth-1:0]   sram_be_o,
   input  logic [DataWidth-1:0] sram_rdata_i
);

   localparam int unsigned CntWidth = $clog2(RspDepth + 1);
   localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

   logic [CntWidth-1:0] used_q;
   logic [CntWidth-1:0] cnt_q;
   logic [PtrWidth-1:0] rd_ptr_q;
   logic [PtrWidth-1:0] wr_ptr_q;
   logic [Latency-1:0]  tag_v_q;
   logic [Latency-1:0]  tag_we_q;
   logic [Latency-1:0]  tag_err_q;

   logic [DataWidth-1:0] mem_data [RspDepth];
   logic                 mem_we   [RspDepth];
   logic                 mem_err  [RspDepth];

   logic accept;
   logic pop;
   logic push;
   logic full;
   logic empty;
   logic err;
   logic push_we;
   logic push_err;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

`ifdef TC_SRAM_RSP_ADAPTER_ADDR_CHECK_EN
   assign err = 32'(req_addr_i) >= NumWords;
`else
   assign err = 1'b0;
`endif

   // Credits cover in-flight tags plus FIFO entries, so a push never overflows.
   assign req_ready_o = !rst_i && (used_q < CntWidth'(RspDepth));
   assign accept      = req_valid_i && req_ready_o;

   assign sram_req_o   = accept && !err;
   assign sram_we_o    = req_we_i;
   assign sram_addr_o  = req_addr_i;
   assign sram_wdata_o = req_wdata_i;
   assign sram_be_o    = req_be_i;

   assign full     = (cnt_q == CntWidth'(RspDepth));
   assign empty    = (cnt_q == '0);
   assign push     = tag_v_q[Latency-1];
   assign push_we  = tag_we_q[Latency-1];
   assign push_err = tag_err_q[Latency-1];

   assign rsp_valid_o = !rst_i && !empty;
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign rsp_rdata_o = rsp_valid_o ? mem_data[rd_ptr_q] : '0;
   assign rsp_we_o    = rsp_valid_o && mem_we[rd_ptr_q];
   assign rsp_err_o   = rsp_valid_o && mem_err[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         used_q    <= '0;
         cnt_q     <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         tag_v_q   <= '0;
         tag_we_q  <= '0;
         tag_err_q <= '0;
      end else begin
         used_q <= used_q + CntWidth'(accept) - CntWidth'(pop);
         cnt_q  <= cnt_q + CntWidth'(push) - CntWidth'(pop);
         tag_v_q[0]   <= accept;
         tag_we_q[0]  <= req_we_i;
         tag_err_q[0] <= err;
         for (int i = 1; i < int'(Latency); i++) begin
            tag_v_q[i]   <= tag_v_q[i-1];
            tag_we_q[i]  <= tag_we_q[i-1];
            tag_err_q[i] <= tag_err_q[i-1];
         end
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         mem_data[wr_ptr_q] <= (push_we || push_err) ? '0 : sram_rdata_i;
         mem_we[wr_ptr_q]   <= push_we;
         mem_err[wr_ptr_q]  <= push_err;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) assert (!(push && full && !pop));
   end
`endif

endmodule

// File: tb/tb_tc_sram_rsp_adapter.sv
// Randomized and directed bench for tc_sram_rsp_adapter with a queue-based
// response model and a behavioural single-port SRAM.
module tb_tc_sram_rsp_adapter;

   localparam int NW  = 12;
   localparam int DW  = 32;
   localparam int LAT = 1;
   localparam int DEP = 3;
   localparam int AW  = 4;
   localparam int BW  = 4;
`ifdef TC_SRAM_RSP_ADAPTER_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [BW-1:0] req_be = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_we;
   logic          rsp_err;
   logic          sram_req;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [BW-1:0] sram_be;
   logic [DW-1:0] sram_rdata = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tc_sram_rsp_adapter #(
      .NumWords(NW), .DataWidth(DW), .ByteWidth(8),
      .Latency(LAT), .RspDepth(DEP)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_we_o(rsp_we), .rsp_err_o(rsp_err),
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
      .sram_rdata_i(sram_rdata)
   );

   // Behavioural SRAM, read latency 1
   logic [DW-1:0] sram_mem [16];
   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < BW; b++)
               if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= sram_mem[sram_addr];
         end
      end
   end

   // Reference model: a word array plus a queue of expected responses
   typedef struct {
      logic [DW-1:0] d;
      logic          we;
      logic          err;
   } rsp_t;

   logic [DW-1:0] ref_mem [16];
   rsp_t          exp_q [$];
   rsp_t          e;
   rsp_t          held;
   logic          stall = 1'b0;
   logic          acc;
   logic          bad;

   initial begin
      for (int i = 0; i < 16; i++) begin
         sram_mem[i] = '0;
         ref_mem[i]  = '0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall = 1'b0;
      end else begin
         acc = req_valid && req_ready;
         bad = CHK && (int'(req_addr) >= NW);
         n_tests++;
         if (sram_req !== (acc && !bad)) begin
            n_fail++;
            $display("FAIL sram_req: got %b expected %b", sram_req, acc && !bad);
         end
         if (rsp_valid && stall) begin
            n_tests++;
            if ({rsp_rdata, rsp_we, rsp_err} !== {held.d, held.we, held.err}) begin
               n_fail++;
               $display("FAIL stable: got %h/%b/%b expected %h/%b/%b",
                        rsp_rdata, rsp_we, rsp_err, held.d, held.we, held.err);
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL spurious_rsp: got rdata %h expected no response", rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               if ({rsp_rdata, rsp_we, rsp_err} !== {e.d, e.we, e.err}) begin
                  n_fail++;
                  $display("FAIL rsp_order: got %h/%b/%b expected %h/%b/%b",
                           rsp_rdata, rsp_we, rsp_err, e.d, e.we, e.err);
               end
            end
         end
         if (acc) begin
            e.we  = req_we;
            e.err = bad;
            e.d   = (req_we || bad) ? '0 : ref_mem[req_addr];
            if (req_we && !bad)
               for (int b = 0; b < BW; b++)
                  if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            exp_q.push_back(e);
         end
         stall = rsp_valid && !rsp_ready;
         held.d   = rsp_rdata;
         held.we  = rsp_we;
         held.err = rsp_err;
      end
   end

   task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] be);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk) #1;
         drive(1'b0, 1'b0, '0, '0, '0);
         rsp_ready = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b0, 4'd0, '0, '0);
      @(negedge clk);
      n_tests++;
      if ({req_ready, sram_req, rsp_valid, rsp_we, rsp_err} !== 5'b0 || rsp_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy%b req%b v%b we%b err%b d%h expected all 0",
                  req_ready, sram_req, rsp_valid, rsp_we, rsp_err, rsp_rdata);
      end
      @(posedge clk) #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_write_read();
      rsp_ready = 1'b1;
      @(posedge clk) #1;
      drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      @(posedge clk) #1;
      drive(1'b1, 1'b0, 4'd3, '0, '0);
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_early: got valid %b expected 0", rsp_valid);
      end
      @(posedge clk) #1;
      drive(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, rsp_we, rsp_err} !== 3'b110 || rsp_rdata !== '0) begin
         n_fail++;
         $display("FAIL wr_rsp: got v%b we%b err%b d%h expected v1 we1 err0 d0",
                  rsp_valid, rsp_we, rsp_err, rsp_rdata);
      end
      @(posedge clk) #1;
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, rsp_we} !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_rsp: got v%b we%b d%h expected v1 we0 deadbeef",
                  rsp_valid, rsp_we, rsp_rdata);
      end
      drain(3);
   endtask

   task automatic test_byte_enable();
      logic got = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk) #1;
      drive(1'b1, 1'b1, 4'd5, 32'h11223344, 4'hF);
      @(posedge clk) #1;
      drive(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0010);
      @(posedge clk) #1;
      drive(1'b1, 1'b0, 4'd5, '0, '0);
      @(posedge clk) #1;
      drive(1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid && !rsp_we) begin
            got = 1'b1;
            n_tests++;
            if (rsp_rdata !== 32'h1122CC44) begin
               n_fail++;
               $display("FAIL byte_en: got %h expected 1122cc44", rsp_rdata);
            end
         end
         @(posedge clk) #1;
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL byte_en_timeout: got no read response expected one");
      end
      drain(3);
   endtask

   task automatic test_back_to_back();
      logic [11:0] v;
      logic [11:0] ev;
      rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk) #1;
         if (i < 8) drive(1'b1, 1'b0, AW'(i), '0, '0);
         else drive(1'b0, 1'b0, '0, '0, '0);
         @(negedge clk);
         v[i]  = rsp_valid;
         ev[i] = (i >= 1 + LAT) && (i < 9 + LAT);
         if (i < 8) begin
            n_tests++;
            if (req_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_ready: cycle %0d got %b expected 1", i, req_ready);
            end
         end
      end
      n_tests++;
      if (v !== ev) begin
         n_fail++;
         $display("FAIL b2b_valid: got %b expected %b", v, ev);
      end
      drain(3);
   endtask

   task automatic test_backpressure();
      int acc_n = 0;
      int pops = 0;
      logic [DW-1:0] d0 = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk) #1;
         drive(1'b1, 1'b0, AW'(i + 2), '0, '0);
         @(negedge clk);
         if (req_ready) acc_n++;
         if (i == 3) d0 = rsp_rdata;
      end
      n_tests++;
      if (acc_n != DEP || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d ready %b expected %0d ready 0", acc_n, req_ready, DEP);
      end
      n_tests++;
      if (rsp_rdata !== d0 || rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stable: got %h v%b expected %h v1", rsp_rdata, rsp_valid, d0);
      end
      for (int j = 0; j < 6; j++) begin
         @(posedge clk) #1;
         rsp_ready = 1'b1;
         drive(1'b0, 1'b0, '0, '0, '0);
         @(negedge clk);
         if (rsp_valid) pops++;
         if (j < 2) begin
            n_tests++;
            if (req_ready !== (j == 1)) begin
               n_fail++;
               $display("FAIL bp_ready: cycle %0d got %b expected %b", j, req_ready, j == 1);
            end
         end
      end
      n_tests++;
      if (pops != DEP) begin
         n_fail++;
         $display("FAIL bp_pops: got %0d expected %0d", pops, DEP);
      end
   endtask

   task automatic test_reset_inflight();
      int acc_n = 0;
      rsp_ready = 1'b1;
      @(posedge clk) #1;
      drive(1'b1, 1'b0, 4'd1, '0, '0);
      @(posedge clk) #1;
      drive(1'b1, 1'b0, 4'd2, '0, '0);
      @(posedge clk) #1;
      rst = 1'b1;
      drive(1'b1, 1'b0, 4'd4, '0, '0);
      @(negedge clk);
      n_tests++;
      if ({sram_req, req_ready, rsp_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid: got req%b rdy%b v%b expected 000", sram_req, req_ready, rsp_valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk) #1;
         rst = 1'b0;
         drive(1'b0, 1'b0, '0, '0, '0);
         @(negedge clk);
         n_tests++;
         if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_flush: cycle %0d got v%b rdy%b expected v0 rdy1", i, rsp_valid, req_ready);
         end
      end
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk) #1;
         drive(1'b1, 1'b0, AW'(i), '0, '0);
         @(negedge clk);
         if (req_ready) acc_n++;
      end
      n_tests++;
      if (acc_n != DEP) begin
         n_fail++;
         $display("FAIL rst_used: got %0d accepts expected %0d", acc_n, DEP);
      end
      drain(6);
   endtask

   task automatic test_addr_check();
      rsp_ready = 1'b1;
      @(posedge clk) #1;
      drive(1'b1, 1'b0, 4'd13, '0, '0);
      @(negedge clk);
      n_tests++;
      if (sram_req !== !CHK) begin
         n_fail++;
         $display("FAIL addr_fwd: got %b expected %b", sram_req, !CHK);
      end
      @(posedge clk) #1;
      drive(1'b0, 1'b0, '0, '0, '0);
      @(posedge clk) #1;
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, rsp_err} !== {1'b1, CHK} || (CHK && rsp_rdata !== '0)) begin
         n_fail++;
         $display("FAIL addr_rsp: got v%b err%b d%h expected v1 err%b", rsp_valid, rsp_err, rsp_rdata, CHK);
      end
      drain(3);
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         @(posedge clk) #1;
         drive($urandom_range(9, 0) < 7, 1'($urandom),
               AW'($urandom_range(CHK ? 15 : NW - 1, 0)), $urandom, BW'($urandom));
         rsp_ready = $urandom_range(9, 0) < 6;
      end
      drain(10);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: got %0d outstanding expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_back_to_back();
      test_backpressure();
      test_reset_inflight();
      test_addr_check();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
